// File: rtl/multicycle_control.sv
// multicycle_control: multicycle sequencer for the single-ALU RV32 core.
// Walks each instruction through FETCH, DECODE, EXEC, MEM and WB states and
// drives the datapath strobes. Memory wait states are bounded by TIMEOUT
// stalled cycles (0 disables the bound); unsupported opcodes and memory
// timeouts trap to a sticky HALT that only reset leaves.
// Optional feature macro: PERF_COUNT_EN adds cycle_count / instret outputs.
module multicycle_control #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        mem_read,
  output logic        mem_write,
  output logic        i_or_d,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_src,
  output logic        reg_write,
  output logic        mem_to_reg,
  output logic        alu_src,
  output logic [1:0]  alu_op,
  output logic        instr_done,
  output logic        fault,
  output logic [3:0]  state
`ifdef PERF_COUNT_EN
  ,
  output logic [31:0] cycle_count,
  output logic [31:0] instret
`endif
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_EXEC_R    = 4'd2,
    S_EXEC_ADDR = 4'd3,
    S_MEM_LD    = 4'd4,
    S_MEM_ST    = 4'd5,
    S_WB_R      = 4'd6,
    S_WB_LD     = 4'd7,
    S_BRANCH    = 4'd8,
    S_HALT      = 4'd9
  } state_e;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;

  // Counter only has to hold TIMEOUT-1 before the trap fires.
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q;
  logic             in_wait;
  logic             timeout_hit;

  assign in_wait     = (state_q == S_FETCH) || (state_q == S_MEM_LD) || (state_q == S_MEM_ST);
  // mem_ready is excluded here, so a same-cycle handshake always beats the trap.
  assign timeout_hit = (TIMEOUT != 0) && in_wait && !mem_ready && (cnt_q == CNT_LIMIT);

  // Next-state selection from current state, opcode and memory handshake.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)        state_d = S_DECODE;
        else if (timeout_hit) state_d = S_HALT;
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_LOAD, OP_STORE: state_d = S_EXEC_ADDR;
          OP_BRANCH:         state_d = S_BRANCH;
          default:           state_d = S_HALT;
        endcase
      end
      S_EXEC_R:    state_d = S_WB_R;
      S_WB_R:      state_d = S_FETCH;
      S_EXEC_ADDR: state_d = (opcode == OP_LOAD) ? S_MEM_LD : S_MEM_ST;
      S_MEM_LD: begin
        if (mem_ready)        state_d = S_WB_LD;
        else if (timeout_hit) state_d = S_HALT;
      end
      S_MEM_ST: begin
        if (mem_ready)        state_d = S_FETCH;
        else if (timeout_hit) state_d = S_HALT;
      end
      S_WB_LD:     state_d = S_FETCH;
      S_BRANCH:    state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      default:     state_d = S_HALT;
    endcase
  end

  // Stall counter: counts mem_ready-low cycles, restarts on any state change.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)       cnt_d = '0;
    else if (in_wait && !mem_ready) cnt_d = cnt_q + 1'b1;
  end

  // State, stall counter and sticky fault registers.
  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_d == S_HALT) fault_q <= 1'b1;
    end
  end

  // Datapath strobes: decoded from state, Mealy on mem_ready/zero, silenced in reset.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    instr_done = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_read = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        S_EXEC_R: alu_op = ALU_RTYPE;
        S_WB_R: begin
          alu_op     = ALU_RTYPE;
          reg_write  = 1'b1;
          instr_done = 1'b1;
        end
        S_EXEC_ADDR: alu_src = 1'b1;
        S_MEM_LD: begin
          mem_read = 1'b1;
          i_or_d   = 1'b1;
          alu_src  = 1'b1;
        end
        S_MEM_ST: begin
          mem_write  = 1'b1;
          i_or_d     = 1'b1;
          alu_src    = 1'b1;
          instr_done = mem_ready;
        end
        S_WB_LD: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          alu_op     = ALU_SUB;
          instr_done = 1'b1;
          pc_write   = zero;
          pc_src     = zero;
        end
        default: ;
      endcase
    end
  end

  assign state = reset ? 4'd0 : state_q;
  assign fault = !reset && fault_q;

`ifdef PERF_COUNT_EN
  logic [31:0] cycle_q;
  logic [31:0] instret_q;

  // Performance counters: live cycles outside HALT and retired instructions.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_q   <= '0;
      instret_q <= '0;
    end else begin
      if (state_q != S_HALT) cycle_q   <= cycle_q + 32'd1;
      if (instr_done)        instret_q <= instret_q + 32'd1;
    end
  end

  assign cycle_count = reset ? 32'd0 : cycle_q;
  assign instret     = reset ? 32'd0 : instret_q;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: the driver issues one input vector
// per cycle and queues the hand-computed output vector expected for that
// cycle; a monitor on the falling edge pops and compares.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src;
  logic        reg_write, mem_to_reg, alu_src, instr_done, fault;
  logic [1:0]  alu_op;
  logic [3:0]  state;
`ifdef PERF_COUNT_EN
  logic [31:0] cycle_count, instret;
`endif

  multicycle_control #(.TIMEOUT(15)) dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .i_or_d     (i_or_d),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_src     (pc_src),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .alu_src    (alu_src),
    .alu_op     (alu_op),
    .instr_done (instr_done),
    .fault      (fault),
    .state      (state)
`ifdef PERF_COUNT_EN
    ,
    .cycle_count(cycle_count),
    .instret    (instret)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // Layout: fault_state_{mem_read mem_write i_or_d}_{ir_write pc_write pc_src}
  //         _{reg_write mem_to_reg alu_src}_alu_op_instr_done
  localparam logic [16:0] E_RESET    = 17'b0_0000_000_000_000_00_0;
  localparam logic [16:0] E_FETCH_W  = 17'b0_0000_100_000_000_00_0;
  localparam logic [16:0] E_FETCH_R  = 17'b0_0000_100_110_000_00_0;
  localparam logic [16:0] E_DECODE   = 17'b0_0001_000_000_000_00_0;
  localparam logic [16:0] E_EXEC_R   = 17'b0_0010_000_000_000_10_0;
  localparam logic [16:0] E_WB_R     = 17'b0_0110_000_000_100_10_1;
  localparam logic [16:0] E_EXEC_A   = 17'b0_0011_000_000_001_00_0;
  localparam logic [16:0] E_MEM_LD   = 17'b0_0100_101_000_001_00_0;
  localparam logic [16:0] E_MEM_ST_W = 17'b0_0101_011_000_001_00_0;
  localparam logic [16:0] E_MEM_ST_R = 17'b0_0101_011_000_001_00_1;
  localparam logic [16:0] E_WB_LD    = 17'b0_0111_000_000_110_00_1;
  localparam logic [16:0] E_BR_T     = 17'b0_1000_000_011_000_01_1;
  localparam logic [16:0] E_BR_N     = 17'b0_1000_000_000_000_01_1;
  localparam logic [16:0] E_HALT     = 17'b1_1001_000_000_000_00_0;

  typedef struct {
    string       name;
    logic [16:0] vec;
    logic        chk_perf;
    logic [31:0] cyc;
    logic [31:0] ret;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic [16:0] act;
  assign act = {fault, state, mem_read, mem_write, i_or_d, ir_write, pc_write, pc_src,
                reg_write, mem_to_reg, alu_src, alu_op, instr_done};

  // Monitor: one expected vector per cycle, compared mid-cycle.
  always @(negedge clk) begin
    exp_t it;
    if (sb_q.size() > 0) begin
      it = sb_q.pop_front();
      checks++;
      if (act !== it.vec) begin
        errors++;
        $display("FAIL %s: outputs got %017b expected %017b", it.name, act, it.vec);
      end
`ifdef PERF_COUNT_EN
      if (it.chk_perf) begin
        checks++;
        if (cycle_count !== it.cyc || instret !== it.ret) begin
          errors++;
          $display("FAIL %s_perf: cycle_count/instret got %0d/%0d expected %0d/%0d",
                   it.name, cycle_count, instret, it.cyc, it.ret);
        end
      end
`endif
    end
  end

  task automatic cyc_p(input string name, input logic rst, input logic [6:0] op,
                       input logic rdy, input logic z, input logic [16:0] e,
                       input logic cp, input logic [31:0] ec, input logic [31:0] er);
    exp_t it;
    @(posedge clk);
    #1;
    reset     = rst;
    opcode    = op;
    mem_ready = rdy;
    zero      = z;
    it.name = name; it.vec = e; it.chk_perf = cp; it.cyc = ec; it.ret = er;
    sb_q.push_back(it);
  endtask

  task automatic cyc(input string name, input logic rst, input logic [6:0] op,
                     input logic rdy, input logic z, input logic [16:0] e);
    cyc_p(name, rst, op, rdy, z, e, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic stall(input string name, input int n, input logic [6:0] op,
                       input logic [16:0] e);
    for (int i = 0; i < n; i++) cyc(name, 1'b0, op, 1'b0, 1'b0, e);
  endtask

  // Zero-wait R-type: retires on its 4th cycle.
  task automatic r_instr(input string tag);
    cyc({tag, "_fetch"},  1'b0, OP_R, 1'b1, 1'b0, E_FETCH_R);
    cyc({tag, "_decode"}, 1'b0, OP_R, 1'b1, 1'b0, E_DECODE);
    cyc({tag, "_exec"},   1'b0, OP_R, 1'b1, 1'b0, E_EXEC_R);
    cyc({tag, "_wb"},     1'b0, OP_R, 1'b1, 1'b0, E_WB_R);
  endtask

  initial begin
    reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;

    // Reset holds everything at zero even with mem_ready/zero high.
    cyc("reset_hold_a", 1'b1, OP_R, 1'b1, 1'b1, E_RESET);
    cyc("reset_hold_b", 1'b1, OP_BR, 1'b1, 1'b1, E_RESET);

    // Three zero-wait R-types: 12 cycles, 3 retires.
    cyc_p("r1_fetch", 1'b0, OP_R, 1'b1, 1'b0, E_FETCH_R, 1'b1, 32'd0, 32'd0);
    cyc("r1_decode", 1'b0, OP_R, 1'b1, 1'b0, E_DECODE);
    cyc("r1_exec",   1'b0, OP_R, 1'b1, 1'b0, E_EXEC_R);
    cyc("r1_wb",     1'b0, OP_R, 1'b1, 1'b0, E_WB_R);
    r_instr("r2");
    r_instr("r3");
    cyc_p("r4_fetch_stall", 1'b0, OP_R, 1'b0, 1'b0, E_FETCH_W, 1'b1, 32'd12, 32'd3);
    cyc("r4_fetch",  1'b0, OP_R, 1'b1, 1'b0, E_FETCH_R);
    cyc("r4_decode", 1'b0, OP_R, 1'b0, 1'b0, E_DECODE);
    cyc("r4_exec",   1'b0, OP_R, 1'b1, 1'b0, E_EXEC_R);
    // Reset in WB_R: no reg_write, counters cleared.
    cyc_p("r4_reset_in_wb", 1'b1, OP_R, 1'b1, 1'b0, E_RESET, 1'b1, 32'd0, 32'd0);

    // Load with 3 MEM_LD stalls: retires on cycle 8.
    cyc_p("ld_fetch", 1'b0, OP_LD, 1'b1, 1'b0, E_FETCH_R, 1'b1, 32'd0, 32'd0);
    cyc("ld_decode", 1'b0, OP_LD, 1'b1, 1'b0, E_DECODE);
    cyc("ld_exec",   1'b0, OP_LD, 1'b1, 1'b0, E_EXEC_A);
    stall("ld_mem_wait", 3, OP_LD, E_MEM_LD);
    cyc("ld_mem_rdy", 1'b0, OP_LD, 1'b1, 1'b0, E_MEM_LD);
    cyc("ld_wb",      1'b0, OP_LD, 1'b1, 1'b0, E_WB_LD);

    // Zero-wait store retires in MEM_ST on cycle 4.
    cyc("st0_fetch",  1'b0, OP_ST, 1'b1, 1'b0, E_FETCH_R);
    cyc("st0_decode", 1'b0, OP_ST, 1'b1, 1'b0, E_DECODE);
    cyc("st0_exec",   1'b0, OP_ST, 1'b1, 1'b0, E_EXEC_A);
    cyc("st0_mem",    1'b0, OP_ST, 1'b1, 1'b0, E_MEM_ST_R);

    // Store with 2 stalls.
    cyc("st2_fetch",  1'b0, OP_ST, 1'b1, 1'b0, E_FETCH_R);
    cyc("st2_decode", 1'b0, OP_ST, 1'b0, 1'b0, E_DECODE);
    cyc("st2_exec",   1'b0, OP_ST, 1'b0, 1'b0, E_EXEC_A);
    stall("st2_mem_wait", 2, OP_ST, E_MEM_ST_W);
    cyc("st2_mem_rdy", 1'b0, OP_ST, 1'b1, 1'b0, E_MEM_ST_R);

    // Branch taken then not taken, both retire on cycle 3.
    cyc("brt_fetch",  1'b0, OP_BR, 1'b1, 1'b1, E_FETCH_R);
    cyc("brt_decode", 1'b0, OP_BR, 1'b1, 1'b1, E_DECODE);
    cyc("brt_branch", 1'b0, OP_BR, 1'b1, 1'b1, E_BR_T);
    cyc("brn_fetch",  1'b0, OP_BR, 1'b1, 1'b0, E_FETCH_R);
    cyc("brn_decode", 1'b0, OP_BR, 1'b1, 1'b0, E_DECODE);
    cyc("brn_branch", 1'b0, OP_BR, 1'b0, 1'b0, E_BR_N);

    // Stall counter restarts on state change: 10 FETCH + 14 MEM_LD stalls, no trap.
    stall("clr_fetch_wait", 10, OP_LD, E_FETCH_W);
    cyc("clr_fetch",  1'b0, OP_LD, 1'b1, 1'b0, E_FETCH_R);
    cyc("clr_decode", 1'b0, OP_LD, 1'b1, 1'b0, E_DECODE);
    cyc("clr_exec",   1'b0, OP_LD, 1'b1, 1'b0, E_EXEC_A);
    stall("clr_mem_wait", 14, OP_LD, E_MEM_LD);
    cyc("clr_mem_rdy", 1'b0, OP_LD, 1'b1, 1'b0, E_MEM_LD);
    cyc("clr_wb",      1'b0, OP_LD, 1'b1, 1'b0, E_WB_LD);

    // mem_ready on the 15th FETCH cycle beats the timeout.
    stall("tb_fetch_wait", 14, OP_R, E_FETCH_W);
    cyc("tb_fetch_15th", 1'b0, OP_R, 1'b1, 1'b0, E_FETCH_R);
    cyc("tb_decode",     1'b0, OP_R, 1'b1, 1'b0, E_DECODE);
    cyc("tb_exec",       1'b0, OP_R, 1'b1, 1'b0, E_EXEC_R);
    cyc("tb_wb",         1'b0, OP_R, 1'b1, 1'b0, E_WB_R);

    // 15 stalled FETCH cycles trap to HALT.
    stall("to_fetch_wait", 15, OP_R, E_FETCH_W);
    cyc("to_halt_a", 1'b0, OP_R, 1'b1, 1'b1, E_HALT);
    cyc("to_halt_b", 1'b0, OP_R, 1'b0, 1'b0, E_HALT);
    cyc("to_reset",  1'b1, OP_R, 1'b1, 1'b0, E_RESET);

    // Unsupported opcode: HALT for 20 cycles, sticky through input activity.
    cyc("bad_fetch",  1'b0, OP_BAD, 1'b1, 1'b0, E_FETCH_R);
    cyc("bad_decode", 1'b0, OP_BAD, 1'b1, 1'b0, E_DECODE);
    for (int i = 0; i < 20; i++)
      cyc("bad_halt", 1'b0, OP_R, i[0], i[1], E_HALT);
    cyc("bad_reset",       1'b1, OP_R, 1'b0, 1'b0, E_RESET);
    cyc("bad_after_reset", 1'b0, OP_R, 1'b0, 1'b0, E_FETCH_W);

    // MEM_ST timeout after 15 stalls.
    cyc("sto_fetch",  1'b0, OP_ST, 1'b1, 1'b0, E_FETCH_R);
    cyc("sto_decode", 1'b0, OP_ST, 1'b1, 1'b0, E_DECODE);
    cyc("sto_exec",   1'b0, OP_ST, 1'b1, 1'b0, E_EXEC_A);
    stall("sto_mem_wait", 15, OP_ST, E_MEM_ST_W);
    cyc("sto_halt",   1'b0, OP_ST, 1'b1, 1'b0, E_HALT);
    cyc("sto_reset",  1'b1, OP_ST, 1'b1, 1'b0, E_RESET);

    // Reset during MEM_ST with mem_ready high: no mem_write, no retire.
    cyc("str_fetch",  1'b0, OP_ST, 1'b1, 1'b0, E_FETCH_R);
    cyc("str_decode", 1'b0, OP_ST, 1'b1, 1'b0, E_DECODE);
    cyc("str_exec",   1'b0, OP_ST, 1'b1, 1'b0, E_EXEC_A);
    cyc("str_mem",    1'b0, OP_ST, 1'b0, 1'b0, E_MEM_ST_W);
    cyc("str_reset",  1'b1, OP_ST, 1'b1, 1'b0, E_RESET);
    cyc("str_after",  1'b0, OP_ST, 1'b0, 1'b0, E_FETCH_W);

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
